ram_ctrl: RTL and testbench
===========================

Name: ram_ctrl

Overview:
- Parametrised single-port synchronous memory with a command sequencer; the successor to the fixed 32x4 switch-driven RAM lab block.
- Accepts single-word READ/WRITE commands plus two multi-cycle bulk modes:
  - FILL: write one value to every address.
  - SCAN: stream every word out and count the words equal to a match value.
- Sits between board I/O (switch/key glue, hex decoders) and any later datapath that needs bulk memory initialisation or inspection.

Parameters:
- DATA_WIDTH, 4, bits per word.
- ADDR_WIDTH, 5, address bits; depth DEPTH = 2**ADDR_WIDTH (derived localparam, not overridable).

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered this cycle.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  2  00 READ, 01 WRITE, 10 FILL, 11 SCAN.
- cmd_addr  in  ADDR_WIDTH  address for READ/WRITE; ignored for FILL/SCAN.
- cmd_data  in  DATA_WIDTH  write data (WRITE), fill value (FILL), match value (SCAN); ignored for READ.
- rd_valid  out  1  rd_data/rd_addr carry a read result this cycle.
- rd_data  out  DATA_WIDTH  read result; holds last value when rd_valid low.
- rd_addr  out  ADDR_WIDTH  address of rd_data.
- busy  out  1  high in FILL or SCAN.
- done  out  1  one-cycle pulse marking FILL/SCAN completion.
- match_count  out  ADDR_WIDTH+1  SCAN match total; updated at SCAN end, held otherwise.

Behaviour:
- Reset (async assert, sync-safe deassert by board):
  - state=IDLE, cmd_ready=1, busy=0, done=0, rd_valid=0.
  - rd_data=0, rd_addr=0, match_count=0, internal counter=0.
  - Memory contents are NOT cleared.
- Handshake: command accepted on a rising edge with cmd_valid && cmd_ready; cmd_valid while not ready is ignored (no queueing).
- IDLE, READ: on accept edge rd_data<=mem[cmd_addr], rd_addr<=cmd_addr, rd_valid<=1. Latency one cycle; rd_valid is high exactly one cycle per READ. Back-to-back READs give rd_valid continuously high.
- IDLE, WRITE: mem[cmd_addr]<=cmd_data on the accept edge; rd_* untouched. A READ of the same address accepted the next cycle returns the new data.
- IDLE, FILL:
  - Accept edge latches cmd_data into fill_val, counter<=0, state->FILL; no write on the accept edge.
  - Each FILL edge: mem[counter]<=fill_val, counter++.
  - Edge writing DEPTH-1: state->IDLE, done<=1 for one cycle.
  - busy high for exactly DEPTH cycles.
- IDLE, SCAN:
  - Accept edge latches match value, counter<=0, acc<=0, state->SCAN.
  - Each SCAN edge: rd_data<=mem[counter], rd_addr<=counter, rd_valid<=1, acc += (mem[counter]==match), counter++.
  - Edge reading DEPTH-1: state->IDLE, done<=1, match_count<=final acc (including the last word).
  - done coincides with the final rd_valid.
  - rd_valid high for exactly DEPTH consecutive cycles, addresses 0..DEPTH-1 ascending.
- Counter width is ADDR_WIDTH; the end test is counter==DEPTH-1, with no reliance on wrap.
- acc/match_count are ADDR_WIDTH+1 bits so an all-match total of DEPTH fits.
- rd_valid is low in every cycle not specified above (WRITE, FILL, idle).
- No new command is accepted on the completion edge; cmd_ready rises in the cycle done is high.
- Reset mid-FILL or mid-SCAN aborts immediately to reset values:
  - Words already written keep their new values.
  - match_count is not updated from the partial acc.

Decomposition:
- Shared package/header ram_ctrl_pkg holds:
  - Opcode constants OP_READ, OP_WRITE, OP_FILL, OP_SCAN.
  - State encodings S_IDLE, S_FILL, S_SCAN.
- Sub-module ram_sp_array(DATA_WIDTH, ADDR_WIDTH): inferred single-port synchronous array with a clock, write enable, address, data in, and registered data out. It has no reset.
- ram_ctrl contains the FSM, counter, accumulator and output registers, and muxes the array address between cmd_addr and counter.

Test Plan:
- Reset, then WRITE addr 5 data 0xA, READ addr 5 -> rd_valid high one cycle after accept, rd_data=0xA, rd_addr=5; done never pulses.
- FILL 0x3 -> busy/cmd_ready=0 for 32 cycles, done pulse once; subsequent READ 0, 17, 31 each return 0x3.
- After FILL 0x3, WRITE addr 2 and addr 9 with 0x7, SCAN 0x3 -> 32 consecutive rd_valid, rd_addr 0..31, rd_data 0x7 at 2 and 9; done with addr 31; match_count=30.
- SCAN 0x3 after FILL 0x3 with no edits -> match_count=32 (needs the 6-bit width); cmd_valid held high during SCAN is ignored and does not alter memory.
- Assert resetn low at FILL cycle 10 with value 0xC over prior contents 0x3 -> outputs reset immediately; READ addr 9 returns 0xC, READ addr 20 returns 0x3; match_count=0.
- Back-to-back READ 0, READ 1, READ 2 -> rd_valid high 3 consecutive cycles with rd_addr 0, 1, 2 in order.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
//   Shared definitions for the RAM command sequencer.
//   - OP_* : command opcodes carried on cmd_op
//   - state_t : controller states (idle, bulk fill, bulk scan)
package ram_ctrl_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_SCAN  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_SCAN = 2'd2
  } state_t;

endpackage

// File: rtl/ram_sp_array.sv
// ram_sp_array
//   Inferred single-port synchronous memory, no reset (contents survive reset).
//   Ports:
//     clock : rising-edge clock
//     we    : write enable, writes din to mem[addr]
//     addr  : shared read/write address
//     din   : write data
//     dout  : registered read data, mem[addr] as seen before this edge's write
module ram_sp_array #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Plain read-first single-port RAM so synthesis maps it onto block/distributed RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl
//   Single-port memory with a command sequencer: single-word READ/WRITE plus
//   bulk FILL (write one value everywhere) and SCAN (stream all words out and
//   count those equal to a match value).
//   Ports:
//     clock, resetn        : clock, asynchronous active-low reset
//     cmd_valid/cmd_ready  : command handshake, ready only while idle
//     cmd_op               : READ / WRITE / FILL / SCAN
//     cmd_addr             : READ/WRITE address
//     cmd_data             : write data, fill value or match value
//     rd_valid/rd_data/rd_addr : read result stream (READ and SCAN)
//     busy                 : high during FILL and SCAN
//     done                 : one-cycle pulse at FILL/SCAN completion
//     match_count          : SCAN match total, updated at SCAN end
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   match_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0] op_val;
  logic [ADDR_WIDTH:0]   acc;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_from_array;
  logic                  accept;
  logic                  last;
  logic                  hit;

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_din;
  logic [DATA_WIDTH-1:0] arr_dout;

  ram_sp_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clock(clock),
    .we   (arr_we),
    .addr (arr_addr),
    .din  (arr_din),
    .dout (arr_dout)
  );

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign last      = (counter == LAST_ADDR);
  assign hit       = (arr_dout == op_val);

  // A READ result comes straight from the array's output register in the cycle
  // after accept; at every other time the held copy is shown.
  assign rd_data = rd_from_array ? arr_dout : rd_data_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // SCAN reads one word ahead: the accept edge fetches word 0 and each scan
  // edge fetches counter+1, so the word for counter is already on arr_dout
  // when its scan edge arrives and the final count includes the last word.
  always_comb begin
    state_next = state;
    arr_we     = 1'b0;
    arr_addr   = cmd_addr;
    arr_din    = cmd_data;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: arr_we = 1'b1;
            OP_FILL:  state_next = S_FILL;
            OP_SCAN: begin
              state_next = S_SCAN;
              arr_addr   = '0;
            end
            default: ;
          endcase
        end
      end
      S_FILL: begin
        arr_we   = 1'b1;
        arr_addr = counter;
        arr_din  = op_val;
        if (last) begin
          state_next = S_IDLE;
        end
      end
      S_SCAN: begin
        arr_addr = counter + ADDR_WIDTH'(1);
        if (last) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      counter       <= '0;
      op_val        <= '0;
      acc           <= '0;
      match_count   <= '0;
      rd_valid      <= 1'b0;
      rd_addr       <= '0;
      rd_data_q     <= '0;
      rd_from_array <= 1'b0;
      done          <= 1'b0;
    end else begin
      rd_valid      <= 1'b0;
      rd_from_array <= 1'b0;
      done          <= 1'b0;
      if (rd_from_array) begin
        rd_data_q <= arr_dout;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_READ: begin
                rd_valid      <= 1'b1;
                rd_from_array <= 1'b1;
                rd_addr       <= cmd_addr;
              end
              OP_FILL, OP_SCAN: begin
                op_val  <= cmd_data;
                counter <= '0;
                acc     <= '0;
              end
              default: ;
            endcase
          end
        end
        S_FILL: begin
          if (last) begin
            counter <= '0;
            done    <= 1'b1;
          end else begin
            counter <= counter + ADDR_WIDTH'(1);
          end
        end
        S_SCAN: begin
          rd_valid  <= 1'b1;
          rd_data_q <= arr_dout;
          rd_addr   <= counter;
          acc       <= acc + (ADDR_WIDTH + 1)'(hit);
          if (last) begin
            counter     <= '0;
            done        <= 1'b1;
            match_count <= acc + (ADDR_WIDTH + 1)'(hit);
          end else begin
            counter <= counter + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl
//   Self-checking bench for ram_ctrl: a memory model predicts every read
//   result, which is queued when the command is issued and compared when the
//   DUT presents it on rd_valid.
module tb_ram_ctrl;
  import ram_ctrl_pkg::*;

  localparam int DW    = 4;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = OP_READ;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic          done;
  logic [AW:0]   match_count;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       sbQueue [$];
  logic [DW-1:0] memModel [DEPTH];
  int            expMatch = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            doneCount = 0;
  int            runLen = 0;
  int            lastRun = 0;

  ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_addr    (rd_addr),
    .busy       (busy),
    .done       (done),
    .match_count(match_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Issue one command, called at posedge+2; returns at posedge+2 after accept.
  task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int waitCycles = 0;
    while (!cmd_ready && waitCycles < 200) begin
      @(posedge clock); #2;
      waitCycles++;
    end
    if (!cmd_ready) checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    case (op)
      OP_READ:  sbQueue.push_back('{addr: addr, data: memModel[addr]});
      OP_WRITE: memModel[addr] = data;
      OP_FILL:  for (int i = 0; i < DEPTH; i++) memModel[i] = data;
      default: begin
        expMatch = 0;
        for (int i = 0; i < DEPTH; i++) begin
          sbQueue.push_back('{addr: AW'(i), data: memModel[i]});
          if (memModel[i] == data) expMatch++;
        end
      end
    endcase
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clock); #2;
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for done, sampled at posedge+2; drops cmd_valid when seen.
  task automatic waitDone();
    int n = 0;
    while (!done && n < 200) begin
      @(posedge clock); #2;
      n++;
    end
    cmd_valid = 1'b0;
    checkOutput("done_seen", 32'(done), 32'd1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Read-result monitor: compare against the scoreboard away from the edge.
  always @(negedge clock) begin : monitor
    rd_exp_t e;
    if (resetn) begin
      if (done) doneCount++;
      if (rd_valid) begin
        runLen++;
        if (sbQueue.size() == 0) begin
          checkOutput("rd_unexpected", 32'(rd_valid), 32'd0);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("rd_addr", 32'(rd_addr), 32'(e.addr));
          checkOutput("rd_data", 32'(rd_data), 32'(e.data));
        end
        if (done) begin
          checkOutput("done_addr", 32'(rd_addr), 32'(DEPTH - 1));
          checkOutput("match_count", 32'(match_count), 32'(expMatch));
        end
      end else begin
        if (runLen != 0) lastRun = runLen;
        runLen = 0;
      end
    end else begin
      runLen = 0;
    end
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) memModel[i] = '0;

    // Reset values
    #12;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_match_count", 32'(match_count), 32'd0);
    resetn = 1'b1;
    @(posedge clock); #2;

    $display("[TB] write/read");
    applyStimulus(OP_WRITE, 5'd5, 4'hA);
    checkOutput("write_no_rd_valid", 32'(rd_valid), 32'd0);
    applyStimulus(OP_READ, 5'd5, 4'h0);
    checkOutput("read_latency", 32'(rd_valid), 32'd1);
    idleCycles(1);
    checkOutput("read_one_cycle", 32'(rd_valid), 32'd0);
    checkOutput("read_hold_data", 32'(rd_data), 32'hA);
    checkOutput("no_done_yet", 32'(doneCount), 32'd0);

    $display("[TB] fill 0x3");
    applyStimulus(OP_FILL, 5'd0, 4'h3);
    n = 0;
    while (busy && n < 100) begin
      if (cmd_ready) checkOutput("fill_cmd_ready", 32'(cmd_ready), 32'd0);
      if (rd_valid) checkOutput("fill_rd_valid", 32'(rd_valid), 32'd0);
      n++;
      @(posedge clock); #2;
    end
    checkOutput("fill_busy_cycles", 32'(n), 32'(DEPTH));
    checkOutput("fill_done", 32'(done), 32'd1);
    checkOutput("fill_ready_on_done", 32'(cmd_ready), 32'd1);
    applyStimulus(OP_READ, 5'd0, 4'h0);
    applyStimulus(OP_READ, 5'd17, 4'h0);
    applyStimulus(OP_READ, 5'd31, 4'h0);
    idleCycles(2);
    checkOutput("fill_done_once", 32'(doneCount), 32'd1);

    $display("[TB] edits then scan 0x3");
    applyStimulus(OP_WRITE, 5'd2, 4'h7);
    applyStimulus(OP_WRITE, 5'd9, 4'h7);
    applyStimulus(OP_SCAN, 5'd0, 4'h3);
    checkOutput("scan_busy", 32'(busy), 32'd1);
    waitDone();
    idleCycles(2);
    checkOutput("scan_run_len", 32'(lastRun), 32'(DEPTH));
    checkOutput("scan_match_30", 32'(match_count), 32'd30);

    $display("[TB] fill then full-match scan with cmd_valid held");
    applyStimulus(OP_FILL, 5'd0, 4'h3);
    waitDone();
    applyStimulus(OP_SCAN, 5'd0, 4'h3);
    cmd_valid = 1'b1;
    cmd_op    = OP_WRITE;
    cmd_addr  = 5'd4;
    cmd_data  = 4'hF;
    waitDone();
    idleCycles(2);
    checkOutput("scan_run_len_full", 32'(lastRun), 32'(DEPTH));
    checkOutput("scan_match_32", 32'(match_count), 32'd32);
    applyStimulus(OP_READ, 5'd4, 4'h0);
    idleCycles(2);

    $display("[TB] reset during fill");
    applyStimulus(OP_FILL, 5'd0, 4'hC);
    repeat (10) @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("abort_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("abort_rd_data", 32'(rd_data), 32'd0);
    checkOutput("abort_match_count", 32'(match_count), 32'd0);
    for (int i = 10; i < DEPTH; i++) memModel[i] = 4'h3;
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #2;
    applyStimulus(OP_READ, 5'd9, 4'h0);
    applyStimulus(OP_READ, 5'd10, 4'h0);
    applyStimulus(OP_READ, 5'd20, 4'h0);
    idleCycles(2);
    checkOutput("abort_match_held", 32'(match_count), 32'd0);

    $display("[TB] back-to-back reads");
    applyStimulus(OP_READ, 5'd0, 4'h0);
    applyStimulus(OP_READ, 5'd1, 4'h0);
    applyStimulus(OP_READ, 5'd2, 4'h0);
    idleCycles(2);
    checkOutput("b2b_run_len", 32'(lastRun), 32'd3);

    checkOutput("total_done_pulses", 32'(doneCount), 32'd4);
    checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
